// File: rtl/deser_rx_ctrl.sv
// Receive-side sequencer for the 8b/10b deserializer path.
// Pulls serial bits from the async FIFO and hunts for K28.5 commas to find the
// 10-bit word boundary. Verifies alignment with further commas before locking,
// then emits framed symbols to the 10b/8b decoder. Decoder code errors are
// tracked, and a run of them drops lock and restarts the hunt.
module deser_rx_ctrl #(
   parameter int LOCK_COMMAS = 2,   // aligned commas (incl. first) to lock, 2..15
   parameter int VERIFY_SYMS = 16,  // symbols allowed in VERIFY before re-hunt
   parameter int ERR_LIMIT   = 4    // consecutive code errors that drop lock, 1..15
) (
   input  logic       i_Rclk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic       i_empty,
   input  logic       i_fifo_bit,
   input  logic       i_code_err,
   output logic       o_R_en,
   output logic [9:0] o_symbol,
   output logic       o_sym_valid,
   output logic       o_is_comma,
   output logic       o_locked,
   output logic       o_lock_lost
);

   localparam int CW = $clog2(LOCK_COMMAS + 1);
   localparam int SW = $clog2(VERIFY_SYMS + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);

   localparam logic [9:0] COMMA_NEG = 10'h17C;  // K28.5, RD-
   localparam logic [9:0] COMMA_POS = 10'h283;  // K28.5, RD+

   typedef enum logic [1:0] {IDLE, HUNT, VERIFY, LOCKED} state_t;

   state_t         state, state_nxt;
   logic [9:0]     shift, shift_nxt;
   logic           bit_vld;
   logic [3:0]     bit_cnt;
   logic [CW-1:0]  comma_cnt;
   logic [SW-1:0]  sym_cnt;
   logic [EW-1:0]  err_cnt, err_nxt;
   logic           err_chk;    // this cycle carries the decoder verdict on the last strobe
   logic           take;       // a FIFO bit is valid and will be consumed
   logic           comma;      // the window including this bit is a K28.5
   logic           boundary;   // this bit completes a 10-bit symbol
   logic           realign;    // start a fresh alignment on this bit
   logic           lock_hit;
   logic           timeout;
   logic           lose;

   // A bit already in flight when enable drops is discarded, not shifted in.
   assign o_R_en    = i_enable && !i_empty && (state != IDLE);
   assign take      = bit_vld && i_enable;
   assign shift_nxt = {i_fifo_bit, shift[9:1]};
   assign comma     = take && ((shift_nxt == COMMA_NEG) || (shift_nxt == COMMA_POS));
   assign boundary  = take && (bit_cnt == 4'd9);

   // Next-state decode, alignment decisions and decoder error accounting.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_nxt = state;
      realign   = 1'b0;
      lock_hit  = 1'b0;
      timeout   = 1'b0;
      lose      = 1'b0;
      err_nxt   = err_cnt;
      case (state)
         IDLE: state_nxt = HUNT;
         HUNT: begin
            if (comma) begin
               realign   = 1'b1;
               state_nxt = VERIFY;
            end
         end
         VERIFY: begin
            if (boundary) begin
               if (comma && (comma_cnt == CW'(LOCK_COMMAS - 1))) begin
                  lock_hit  = 1'b1;
                  state_nxt = LOCKED;
               end else if (sym_cnt == SW'(VERIFY_SYMS - 1)) begin
                  timeout   = 1'b1;
                  state_nxt = HUNT;
               end
            end else if (comma) begin
               // Off-boundary comma: trust the newer alignment and restart verification.
               realign = 1'b1;
            end
         end
         LOCKED: begin
            if (err_chk) begin
               if (!i_code_err)                   err_nxt = '0;
               else if (err_cnt != EW'(ERR_LIMIT)) err_nxt = err_cnt + EW'(1);
            end
            if (err_nxt == EW'(ERR_LIMIT)) begin
               lose      = 1'b1;
               state_nxt = HUNT;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!i_enable) state_nxt = IDLE;
   end

   // State register.
   always_ff @(posedge i_Rclk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Shift register, alignment counters, error counter and registered outputs.
   always_ff @(posedge i_Rclk) begin
      if (!i_rst_n || !i_enable) begin
         bit_vld     <= 1'b0;
         shift       <= '0;
         bit_cnt     <= '0;
         comma_cnt   <= '0;
         sym_cnt     <= '0;
         err_cnt     <= '0;
         err_chk     <= 1'b0;
         o_sym_valid <= 1'b0;
         o_is_comma  <= 1'b0;
         o_locked    <= 1'b0;
         o_lock_lost <= 1'b0;
         // The last emitted symbol is kept across an enable drop; only reset clears it.
         if (!i_rst_n) o_symbol <= '0;
      end else begin
         bit_vld     <= o_R_en;
         err_chk     <= o_sym_valid;
         err_cnt     <= err_nxt;
         o_sym_valid <= 1'b0;
         o_is_comma  <= 1'b0;
         o_lock_lost <= lose;

         if (take) begin
            shift   <= shift_nxt;
            bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
         end

         if (realign) begin
            bit_cnt   <= '0;
            comma_cnt <= CW'(1);
            sym_cnt   <= '0;
         end else if (state == VERIFY && boundary) begin
            sym_cnt <= sym_cnt + SW'(1);
            if (comma) comma_cnt <= comma_cnt + CW'(1);
            if (timeout) begin
               comma_cnt <= '0;
               sym_cnt   <= '0;
            end
         end

         if (lock_hit) o_locked <= 1'b1;

         // Losing sync on a boundary edge suppresses that edge's emission.
         if (lose) begin
            o_locked  <= 1'b0;
            comma_cnt <= '0;
            sym_cnt   <= '0;
            err_cnt   <= '0;
         end else if (state == LOCKED && boundary) begin
            o_symbol    <= shift_nxt;
            o_sym_valid <= 1'b1;
            o_is_comma  <= comma;
         end
      end
   end

endmodule

// File: tb/tb_deser_rx_ctrl.sv
// Self-checking bench for deser_rx_ctrl: a FIFO model feeds a bit stream, and a
// rule-level reference model predicts every output on every cycle. Directed
// scenarios cover reset, alignment, realignment, loss of sync, FIFO stalls and
// enable drops; a randomized phase follows.
module tb_deser_rx_ctrl;

   localparam int LOCK_COMMAS = 2;
   localparam int VERIFY_SYMS = 16;
   localparam int ERR_LIMIT   = 4;

   logic       clk = 1'b0;
   logic       rst_n, enable, empty, fifo_bit, code_err;
   logic       r_en, sym_valid, is_comma, locked, lock_lost;
   logic [9:0] symbol;

   always #5 clk = ~clk;

   deser_rx_ctrl #(
      .LOCK_COMMAS(LOCK_COMMAS),
      .VERIFY_SYMS(VERIFY_SYMS),
      .ERR_LIMIT  (ERR_LIMIT)
   ) dut (
      .i_Rclk     (clk),
      .i_rst_n    (rst_n),
      .i_enable   (enable),
      .i_empty    (empty),
      .i_fifo_bit (fifo_bit),
      .i_code_err (code_err),
      .o_R_en     (r_en),
      .o_symbol   (symbol),
      .o_sym_valid(sym_valid),
      .o_is_comma (is_comma),
      .o_locked   (locked),
      .o_lock_lost(lock_lost)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- stimulus controls ----------------
   bit q_bits[$];          // FIFO contents, head = next bit out
   bit cur_bit, have_bit;  // FIFO read data for the cycle after a read
   bit b_rst = 1'b0, b_en = 1'b1, b_stall = 1'b0;
   bit err_plan[$];        // code_err values for upcoming post-strobe cycles
   int err_rate = 0;       // percent chance of code_err when no plan is queued
   int lost_seen = 0;

   // Snapshot of DUT outputs taken mid-cycle by tick()
   logic       obs_ren, obs_valid, obs_comma, obs_locked, obs_lost;
   logic [9:0] obs_sym;

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_HUNT, M_VERIFY, M_LOCKED} mstate_t;
   mstate_t    m_state;
   int         m_win;                     // last ten received bits, newest at bit 9
   bit         m_pend, m_chk;
   int         m_phase, m_commas, m_syms, m_errs;
   logic [9:0] e_sym;
   bit         e_valid, e_comma, e_locked, e_lost;

   task automatic model_clear();
      m_state = M_IDLE; m_win = 0; m_pend = 0; m_chk = 0;
      m_phase = 0; m_commas = 0; m_syms = 0; m_errs = 0;
      e_valid = 0; e_comma = 0; e_locked = 0; e_lost = 0;
   endtask

   task automatic model_step(input bit rst, input bit en, input bit emp, input bit fb, input bit ce);
      bit ren, take, cm, bnd, chk_now;
      int w;
      ren = en && !emp && (m_state != M_IDLE);
      if (!rst) begin
         model_clear();
         e_sym = '0;
         return;
      end
      if (!en) begin
         model_clear();  // symbol register is retained
         return;
      end
      take    = m_pend;
      m_pend  = ren;
      chk_now = m_chk;
      m_chk   = e_valid;
      e_valid = 0; e_comma = 0; e_lost = 0;
      cm = 0;
      w  = m_win;
      if (take) begin
         w     = (m_win >> 1) | (int'(fb) << 9);
         m_win = w;
         cm    = (w == 'h17C) || (w == 'h283);
      end
      bnd = take && ((m_phase % 10) == 9);
      case (m_state)
         M_IDLE: m_state = M_HUNT;
         M_HUNT: if (take && cm) begin
            m_state = M_VERIFY; m_phase = 0; m_commas = 1; m_syms = 0;
         end
         M_VERIFY: if (take) begin
            if (bnd) begin
               m_phase++;
               m_syms++;
               if (cm) m_commas++;
               if (cm && m_commas >= LOCK_COMMAS) begin
                  m_state = M_LOCKED; e_locked = 1;
               end else if (m_syms >= VERIFY_SYMS) begin
                  m_state = M_HUNT; m_commas = 0; m_syms = 0;
               end
            end else if (cm) begin
               m_phase = 0; m_commas = 1; m_syms = 0;
            end else begin
               m_phase++;
            end
         end
         M_LOCKED: begin
            if (chk_now) m_errs = ce ? ((m_errs < ERR_LIMIT) ? m_errs + 1 : m_errs) : 0;
            if (m_errs >= ERR_LIMIT) begin
               m_state = M_HUNT; e_locked = 0; e_lost = 1;
               m_commas = 0; m_syms = 0; m_errs = 0;
            end else if (take) begin
               if (bnd) begin
                  e_sym = w[9:0]; e_valid = 1; e_comma = cm;
               end
               m_phase++;
            end
         end
         default: m_state = M_IDLE;
      endcase
   endtask

   // ---------------- helpers ----------------
   task automatic push_sym(input logic [9:0] v);
      for (int i = 0; i < 10; i++) q_bits.push_back(v[i]);
   endtask

   function automatic logic [9:0] rand_data();
      logic [9:0] v;
      do v = 10'($urandom); while (v == 10'h17C || v == 10'h283);
      return v;
   endfunction

   // One clock: drive inputs on the falling edge, compare mid-cycle, advance model on the rising edge.
   task automatic tick();
      bit emp, fb, ce, ren;
      @(negedge clk);
      emp = b_stall || (q_bits.size() == 0);
      fb  = have_bit ? cur_bit : 1'($urandom);
      if (m_chk && err_plan.size() > 0) ce = err_plan.pop_front();
      else                              ce = ($urandom_range(99) < err_rate);
      rst_n = b_rst; enable = b_en; empty = emp; fifo_bit = fb; code_err = ce;
      ren = b_en && !emp && (m_state != M_IDLE);
      #1;
      check("r_en",      32'(r_en),      32'(ren));
      check("symbol",    32'(symbol),    32'(e_sym));
      check("sym_valid", 32'(sym_valid), 32'(e_valid));
      check("is_comma",  32'(is_comma),  32'(e_comma));
      check("locked",    32'(locked),    32'(e_locked));
      check("lock_lost", 32'(lock_lost), 32'(e_lost));
      obs_ren = r_en; obs_sym = symbol; obs_valid = sym_valid;
      obs_comma = is_comma; obs_locked = locked; obs_lost = lock_lost;
      if (lock_lost === 1'b1) lost_seen++;
      @(posedge clk);
      model_step(b_rst, b_en, emp, fb, ce);
      if (ren) begin
         cur_bit  = q_bits.pop_front();
         have_bit = 1'b1;
      end else begin
         have_bit = 1'b0;
      end
   endtask

   task automatic wait_locked(input string tag, input bit want, input int limit);
      for (int i = 0; i < limit && obs_locked !== want; i++) tick();
      check(tag, 32'(obs_locked), 32'(want));
   endtask

   task automatic wait_strobe(input string tag, input int limit);
      tick();
      for (int i = 0; i < limit && obs_valid !== 1'b1; i++) tick();
      check(tag, 32'(obs_valid), 32'd1);
   endtask

   task automatic wait_fifo(input string tag, input int size, input int limit);
      for (int i = 0; i < limit && q_bits.size() != size; i++) tick();
      check(tag, 32'(q_bits.size()), 32'(size));
   endtask

   task automatic push_fill(input int n);
      for (int i = 0; i < n; i++) push_sym(i[0] ? 10'h2AA : 10'h155);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int en_off;
      int r;
      rst_n = 1'b0; enable = 1'b1; empty = 1'b1; fifo_bit = 1'b0; code_err = 1'b0;
      model_clear();
      e_sym = '0;
      @(posedge clk);
      model_step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Reset held with enable high, then release; stream: 3 junk bits, 17C, 283, 155, filler
      q_bits.push_back(1'b1); q_bits.push_back(1'b1); q_bits.push_back(1'b0);
      push_sym(10'h17C); push_sym(10'h283); push_sym(10'h155);
      push_fill(6);
      repeat (3) tick();
      check("rst_ren",    32'(obs_ren),    32'd0);
      check("rst_locked", 32'(obs_locked), 32'd0);
      check("rst_valid",  32'(obs_valid),  32'd0);
      check("rst_symbol", 32'(obs_sym),    32'd0);
      b_rst = 1'b1;
      tick();
      tick();
      check("ren_after_rst", 32'(obs_ren), 32'd1);

      // Alignment at offset 3: lock after the second comma, first emitted symbol is 155
      wait_locked("lock_offset3", 1'b1, 80);
      wait_strobe("first_strobe", 30);
      check("first_sym",       32'(obs_sym),    32'h155);
      check("first_not_comma", 32'(obs_comma),  32'd0);

      // Three errors then a clean symbol keep lock
      push_fill(8);
      err_plan = '{1'b1, 1'b1, 1'b1, 1'b0};
      lost_seen = 0;
      repeat (70) tick();
      check("errs3_locked", 32'(obs_locked), 32'd1);
      check("errs3_nolost", 32'(lost_seen),  32'd0);

      // Four consecutive errors drop lock with a single pulse
      push_fill(8);
      err_plan = '{1'b1, 1'b1, 1'b1, 1'b1};
      lost_seen = 0;
      repeat (70) tick();
      check("errs4_lost",     32'(lost_seen),  32'd1);
      check("errs4_unlocked", 32'(obs_locked), 32'd0);
      check("errs4_hunting",  32'(obs_ren),    32'd1);

      // Relock, then drop enable mid-symbol
      q_bits.delete();
      push_sym(10'h17C); push_sym(10'h283); push_fill(4);
      wait_locked("relock_pre_drop", 1'b1, 80);
      wait_strobe("strobe_pre_drop", 30);
      repeat (4) tick();
      lost_seen = 0;
      b_en = 1'b0;
      tick();
      check("drop_ren", 32'(obs_ren), 32'd0);
      tick();
      check("drop_unlocked", 32'(obs_locked), 32'd0);
      q_bits.delete();
      repeat (2) tick();
      check("drop_nolost", 32'(lost_seen), 32'd0);
      b_en = 1'b1;

      // Misaligned comma in VERIFY: 17C, 4 junk bits, 283 (off-boundary) -> realign, no lock yet
      push_sym(10'h17C);
      q_bits.push_back(1'b0); q_bits.push_back(1'b1);
      q_bits.push_back(1'b0); q_bits.push_back(1'b1);
      push_sym(10'h283);
      wait_fifo("realign_drain", 0, 100);
      repeat (4) tick();
      check("realign_no_lock", 32'(obs_locked), 32'd0);
      push_sym(10'h17C); push_fill(4);
      wait_locked("realign_lock", 1'b1, 40);

      // Empty stall of 7 cycles after bit 5 of a symbol
      wait_fifo("stall_drain", 0, 100);
      repeat (3) tick();
      push_sym(10'h2A5); push_sym(10'h0F0);
      wait_fifo("stall_bit5", 15, 40);
      b_stall = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("stall_ren", 32'(obs_ren), 32'd0);
      end
      b_stall = 1'b0;
      wait_strobe("stall_strobe", 30);
      check("stall_sym",    32'(obs_sym),    32'h2A5);
      check("stall_locked", 32'(obs_locked), 32'd1);
      wait_strobe("stall_next_strobe", 30);
      check("stall_next_sym", 32'(obs_sym), 32'h0F0);

      // Randomized phase: commas, random data, slips, stalls, errors, enable drops, one reset
      err_rate = 35;
      en_off = 0;
      for (int n = 0; n < 3000; n++) begin
         if (q_bits.size() < 30) begin
            r = $urandom_range(15);
            if (r < 4)       push_sym(r[0] ? 10'h17C : 10'h283);
            else if (r == 4) repeat ($urandom_range(4, 1)) q_bits.push_back(1'($urandom));
            else             push_sym(rand_data());
         end
         b_stall = ($urandom_range(7) == 0);
         if (n == 1500) b_rst = 1'b0;
         if (n == 1503) b_rst = 1'b1;
         if (b_en && $urandom_range(499) == 0) begin
            b_en   = 1'b0;
            en_off = $urandom_range(5, 1);
         end else if (!b_en) begin
            if (en_off == 0) b_en = 1'b1;
            else             en_off--;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/deser_rx_ctrl.md
# deser_rx_ctrl

Receive-side sequencer for the 8b/10b deserializer path. It drives the async FIFO read enable and consumes the serial bit stream from the FIFO. It hunts for K28.5 commas to find the 10-bit word boundary, then issues framed symbols with a valid strobe to the 10b/8b decoder. It tracks decoder code errors, declares loss of sync, and re-hunts.

## Interface
- LOCK_COMMAS, 2: aligned commas (including the first) required to reach LOCKED; legal range 2-15.
- VERIFY_SYMS, 16: symbols allowed in VERIFY before timing out to HUNT.
- ERR_LIMIT, 4: consecutive decoder code errors that force loss of sync; legal range 1-15.
- i_Rclk  in  1  read-domain clock.
- i_rst_n  in  1  reset: synchronous, active-low, sampled on i_Rclk.
- i_enable  in  1  run enable; low forces IDLE.
- i_empty  in  1  FIFO empty flag, i_Rclk domain.
- i_fifo_bit  in  1  FIFO read data; valid the cycle after o_R_en=1.
- i_code_err  in  1  decoder invalid-code flag; sampled only the cycle after o_sym_valid.
- o_R_en  out  1  FIFO read enable (combinational).
- o_symbol  out  10  framed symbol; first-received bit in [0].
- o_sym_valid  out  1  one-cycle strobe, o_symbol valid.
- o_is_comma  out  1  qualifies o_sym_valid; the symbol is K28.5.
- o_locked  out  1  high in LOCKED.
- o_lock_lost  out  1  one-cycle pulse on LOCKED->HUNT.

## Operation
- Reset: state IDLE. o_symbol=0, o_sym_valid=0, o_is_comma=0, o_locked=0, o_lock_lost=0. Internal shift register, bit counter, comma counter, symbol counter and error counter all cleared. o_R_en=0.
- o_R_en = i_enable && !i_empty && state!=IDLE. A registered flag bit_vld <= o_R_en marks i_fifo_bit valid the following cycle.
- Shift: on bit_vld, shift_nxt = {i_fifo_bit, shift[9:1]} and shift <= shift_nxt.
- Commas: shift_nxt == 10'h17C (RD-) or 10'h283 (RD+).
- IDLE -> HUNT when i_enable=1.
- HUNT: check for a comma on every valid bit. On a comma: go to VERIFY, bit_cnt<=0, comma_cnt<=1, sym_cnt<=0. No symbols are emitted.
- VERIFY: bit_cnt counts 0..9 and wraps on each valid bit. At bit_cnt==9 (symbol boundary), sym_cnt increments. If the symbol is a comma, comma_cnt increments.
  - comma_cnt reaches LOCK_COMMAS -> LOCKED.
  - sym_cnt reaches VERIFY_SYMS without reaching lock -> HUNT.
  - A comma at a non-boundary position -> treat as a fresh HUNT hit: stay in VERIFY, realign bit_cnt<=0, comma_cnt<=1, sym_cnt<=0.
- LOCKED:
  - At every boundary: o_symbol<=shift_nxt, o_sym_valid<=1, o_is_comma<=comma.
  - Commas at non-boundary positions are ignored.
  - Cycle after o_sym_valid: i_code_err=1 increments err_cnt (saturating); i_code_err=0 clears err_cnt.
  - err_cnt reaches ERR_LIMIT -> HUNT. o_lock_lost=1 for one cycle, o_locked=0; comma_cnt, sym_cnt and err_cnt are cleared.
- i_enable low in any state:
  - Next state is IDLE and o_R_en drops the same cycle.
  - A bit already in flight (bit_vld=1) is discarded.
  - All counters are cleared. o_locked=0. o_lock_lost is not pulsed.
- FIFO empty: o_R_en=0 and there is no bit_vld. The state and all counters hold, so a stall mid-symbol keeps alignment.
- Reset mid-operation: the full reset values above are applied on that edge, regardless of state.

## Timing
- Bit latency: bit sampled one cycle after o_R_en.
- Symbol latency: o_sym_valid is asserted on the edge after the cycle the 10th bit is sampled. Minimum spacing is 10 cycles with an unstalled FIFO.
- Lock latency from the first comma's last bit: (LOCK_COMMAS-1)*10 bit-cycles.
- o_locked rises on the same edge as the state change. The locking comma is the last VERIFY symbol and is not emitted.
- Simultaneous events at a boundary:
  - i_code_err evaluation for the previous symbol and the current emission are independent.
  - A loss of sync decided on the same edge as a boundary suppresses that emission.
- Counter widths: bit_cnt is 4 bits; comma_cnt, err_cnt and sym_cnt are sized to their parameter. There is no wrap past a limit.

## Test plan
- Reset with i_enable=1: hold i_rst_n=0 for 3 cycles -> all outputs 0 and o_R_en=0. After release -> o_R_en=1 the next cycle when i_empty=0.
- Alignment at offset 3: feed 3 junk bits, then 17C, 283, 0x155 -> o_locked=1 after the second comma. The next o_sym_valid carries o_symbol=0x155 with o_is_comma=0.
- Misaligned comma: in VERIFY, inject a comma 4 bits after a boundary -> realign to it. Lock is reached only after one further aligned comma.
- Loss of sync: while LOCKED, assert i_code_err on 4 consecutive post-strobe cycles -> o_lock_lost pulse, o_locked=0, state HUNT. Three errors followed by a clean symbol -> still locked.
- Empty stall: raise i_empty for 7 cycles after bit 5 of a symbol -> o_R_en=0 throughout the stall. After the stall the symbol is emitted intact and alignment is kept.
- Enable drop: drop i_enable mid-symbol while LOCKED -> o_R_en=0 the same cycle, IDLE, o_locked=0, no o_lock_lost. Re-enable -> re-hunt and relock.
